// File: rtl/tetris_pkg.sv
// Shared opcodes, scheduler state encoding, pending-request record and the drop-period helper
// for the Tetris move scheduler.
package tetris_pkg;

  localparam int LEVEL_W = 4;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_ROT   = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_LOCK  = 3'd5;
  localparam logic [2:0] OP_SPAWN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PICK     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_HALT     = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic spawn;
    logic lock;
    logic rot;
    logic left;
    logic right;
    logic drop;
  } pend_t;

  localparam pend_t PEND_RST = '{spawn: 1'b1, default: 1'b0};

  // Fixed priority: a new piece first, then finishing the old one, then player moves, gravity last.
  function automatic logic [2:0] pick_op(input pend_t p);
    if (p.spawn)      return OP_SPAWN;
    else if (p.lock)  return OP_LOCK;
    else if (p.rot)   return OP_ROT;
    else if (p.left)  return OP_LEFT;
    else if (p.right) return OP_RIGHT;
    else if (p.drop)  return OP_DOWN;
    return OP_NONE;
  endfunction

  function automatic logic [7:0] drop_period(input logic [LEVEL_W-1:0] lvl,
                                             input logic [7:0] base,
                                             input logic [7:0] step,
                                             input logic [7:0] floor_v);
    logic [7:0] dec;
    dec = 8'(lvl) * step;
    if (dec >= base)                 return floor_v;
    else if ((base - dec) < floor_v) return floor_v;
    return base - dec;
  endfunction

endpackage

// File: rtl/tetris_move_sched_if.sv
// Command/response port between the move scheduler (master) and the board engine (slave).
// Handshake: a command transfers on the cycle cmd_valid && cmd_ready; cmd_op is held stable while
// cmd_valid waits for cmd_ready; rsp_valid is a single-cycle result, rsp_blocked qualified by it.
interface tetris_move_sched_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_blocked;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, rsp_valid, rsp_blocked
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, rsp_valid, rsp_blocked
  );
endinterface

// File: rtl/tetris_gravity_timer.sv
// Frame counter for gravity: counts frame ticks and emits a drop request once per
// level-dependent drop period.
module tetris_gravity_timer
  import tetris_pkg::*;
#(
  parameter int DROP_FRAMES = 30,
  parameter int LEVEL_STEP  = 2,
  parameter int MIN_DROP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               drop_evt_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period;
  logic       wrap;

  assign period = drop_period(level_i, 8'(DROP_FRAMES), 8'(LEVEL_STEP), 8'(MIN_DROP));
  // >= rather than == so a period that shrinks under a high count still wraps right away
  assign wrap   = (cnt_q >= (period - 8'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (frame_tick_i) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
  end

  assign drop_evt_o = frame_tick_i & wrap;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tetris_move_sched.sv
// Per-frame move scheduler: latches key and gravity requests and issues them one at a time to the
// board engine. Define AUTO_REPEAT_EN to auto-repeat a held left/right key every REPEAT_FRAMES frames.
module tetris_move_sched
  import tetris_pkg::*;
#(
  parameter int DROP_FRAMES = 30,
  parameter int LEVEL_STEP  = 2,
  parameter int MIN_DROP    = 4
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_FRAMES = 6
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_sw,
  input  logic                key_l,
  input  logic                key_r,
  input  logic                vs_in,
  tetris_move_sched_if.master bus,
  input  logic                line_clr,
  input  logic                game_over,
  output logic [LEVEL_W-1:0]  level,
  output logic                halted,
  output sched_state_e        dbg_state
);

  logic sw_q, l_q, r_q, vs_q, vs_prev_q;
  logic frame_tick, fall_sw, fall_l_raw, fall_r_raw, fall_l, fall_r;
  logic rep_l, rep_r, drop_evt, xfer;
  sched_state_e       state_q, state_d;
  logic [2:0]         op_q, op_d;
  pend_t              pend_q, pend_d;
  logic [LEVEL_W-1:0] level_q;

  assign frame_tick = vs_q & ~vs_prev_q;
  assign fall_sw    = sw_q & ~key_sw;
  assign fall_l_raw = l_q & ~key_l;
  assign fall_r_raw = r_q & ~key_r;
  // Left and right together are ambiguous, so neither is taken.
  assign fall_l     = fall_l_raw & ~fall_r_raw;
  assign fall_r     = fall_r_raw & ~fall_l_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q      <= 1'b1;
      l_q       <= 1'b1;
      r_q       <= 1'b1;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      sw_q      <= key_sw;
      l_q       <= key_l;
      r_q       <= key_r;
      vs_q      <= vs_in;
      vs_prev_q <= vs_q;
    end
  end

  tetris_gravity_timer #(
    .DROP_FRAMES (DROP_FRAMES),
    .LEVEL_STEP  (LEVEL_STEP),
    .MIN_DROP    (MIN_DROP)
  ) u_gravity (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .level_i      (level_q),
    .drop_evt_o   (drop_evt)
  );

`ifdef AUTO_REPEAT_EN
  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic       hold_l, hold_r;

  assign hold_l = ~key_l & key_r;
  assign hold_r = key_l & ~key_r;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_l     = 1'b0;
    rep_r     = 1'b0;
    if (fall_l_raw || fall_r_raw || !(hold_l || hold_r)) begin
      rep_cnt_d = 8'd0;
    end else if (frame_tick) begin
      if (rep_cnt_q == 8'(REPEAT_FRAMES - 1)) begin
        rep_cnt_d = 8'd0;
        rep_l     = hold_l;
        rep_r     = hold_r;
      end else begin
        rep_cnt_d = rep_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_l = 1'b0;
  assign rep_r = 1'b0;
`endif

  assign xfer = (state_q == ST_ISSUE) & bus.cmd_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pend_d  = pend_q;

    // Clear before set, so an event landing on its own consume cycle survives.
    if (xfer) begin
      case (op_q)
        OP_SPAWN: pend_d.spawn = 1'b0;
        OP_LOCK:  pend_d.lock  = 1'b0;
        OP_ROT:   pend_d.rot   = 1'b0;
        OP_LEFT:  pend_d.left  = 1'b0;
        OP_RIGHT: pend_d.right = 1'b0;
        OP_DOWN:  pend_d.drop  = 1'b0;
        default:  ;
      endcase
    end
    pend_d.rot   = pend_d.rot   | fall_sw;
    pend_d.left  = pend_d.left  | fall_l | rep_l;
    pend_d.right = pend_d.right | fall_r | rep_r;
    pend_d.drop  = pend_d.drop  | drop_evt;

    case (state_q)
      ST_IDLE: if (frame_tick) state_d = ST_PICK;
      ST_PICK: begin
        op_d    = pick_op(pend_q);
        state_d = (op_d != OP_NONE) ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: if (bus.cmd_ready) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          state_d = ST_PICK;
          if (op_q == OP_DOWN && bus.rsp_blocked) pend_d.lock  = 1'b1;
          if (op_q == OP_LOCK)                    pend_d.spawn = 1'b1;
        end
      end
      ST_HALT: pend_d = '0;
      default: state_d = ST_IDLE;
    endcase

    if (game_over) begin
      state_d = ST_HALT;
      op_d    = OP_NONE;
      pend_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      pend_q  <= PEND_RST;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      if (line_clr && level_q != {LEVEL_W{1'b1}}) level_q <= level_q + 4'd1;
    end
  end

  assign bus.cmd_valid = (state_q == ST_ISSUE);
  assign bus.cmd_op    = op_q;
  assign level         = level_q;
  assign halted        = (state_q == ST_HALT);
  assign dbg_state     = state_q;

endmodule
